// File: rtl/alu_serial_if.sv
// alu_serial_if -- issue-stage <-> serial ALU sequencer bundle.
//
// Purpose: groups the request (start/op/a/b) and response
// (busy/done/result/flags) signals of alu_serial_ctrl.
// Parameter W: operand/result width.
// Optional feature macro: ALU_SERIAL_OVF_EN adds the overflow flag.
//
// Signals:
//   start    issue -> alu   request, sampled only when the sequencer is idle
//   op[2:0]  issue -> alu   operation code
//   a, b     issue -> alu   operands
//   busy     alu -> issue   high while an operation is running or completing
//   done     alu -> issue   one-cycle pulse when result is valid
//   result   alu -> issue   W-bit result
//   cout     alu -> issue   carry out of bit W-1
//   zero     alu -> issue   result == 0
//   overflow alu -> issue   signed overflow (ALU_SERIAL_OVF_EN only)
interface alu_serial_if #(parameter int W = 8);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
`ifdef ALU_SERIAL_OVF_EN
  logic         overflow;

  modport master (output start, op, a, b,
                  input  busy, done, result, cout, zero, overflow);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, cout, zero, overflow);
`else
  modport master (output start, op, a, b,
                  input  busy, done, result, cout, zero);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, cout, zero);
`endif
endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl -- bit-serial ALU sequencer.
//
// Purpose: time-shares a single 1-bit ALU slice across all W bit positions,
// LSB first, producing a full W-bit result after W RUN cycles. Owns the
// operand shift registers, carry flip-flop, bit counter and result register,
// and reconstructs set-less-than from the MSB sum bit.
// Optional feature macro: ALU_SERIAL_OVF_EN adds the registered overflow flag.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    alu_serial_if.slave (start/op/a/b in, busy/done/result/cout/zero
//          [/overflow] out)
module alu_serial_ctrl #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        reset,
  alu_serial_if.slave bus
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res_sh;
  logic [W-1:0]  result_q;
  logic [2:0]    op_q;
  logic          carry;
  logic [IW-1:0] idx;
  logic          cout_q;
  logic          zero_q;
  logic          accept;
  logic          last;
  logic          bv;
  logic          sum_bit;
  logic          carry_next;
  logic          slice_bit;
  logic [W-1:0]  final_res;
`ifdef ALU_SERIAL_OVF_EN
  logic          ovf_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // One slice evaluation: operand B is inverted for the op[2] variants, and
  // SLT slots contribute 0 to the shifted result since only the final sign
  // bit matters.
  always_comb begin
    last       = (idx == LAST_IDX);
    bv         = b_sh[0] ^ op_q[2];
    sum_bit    = a_sh[0] ^ bv ^ carry;
    carry_next = (a_sh[0] & bv) | (a_sh[0] & carry) | (bv & carry);
    case (op_q[1:0])
      2'b00:   slice_bit = a_sh[0] & bv;
      2'b01:   slice_bit = a_sh[0] | bv;
      2'b10:   slice_bit = sum_bit;
      default: slice_bit = 1'b0;
    endcase
    if (op_q[1:0] == 2'b11) final_res = {{(W-1){1'b0}}, sum_bit};
    else                    final_res = {slice_bit, res_sh[W-1:1]};
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, and register
  // the visible result and flags on the last bit so they only move at
  // RUN->DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op_q     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      op_q   <= bus.op;
      carry  <= bus.op[2];
      idx    <= '0;
      res_sh <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= carry_next;
      idx    <= idx + 1'b1;
      res_sh <= {slice_bit, res_sh[W-1:1]};
      if (last) begin
        result_q <= final_res;
        cout_q   <= carry_next;
        zero_q   <= (final_res == '0);
`ifdef ALU_SERIAL_OVF_EN
        // Carry into the MSB differs from carry out: signed overflow.
        ovf_q    <= (op_q[1:0] == 2'b10) & (carry ^ carry_next);
`endif
      end
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
  assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl -- self-checking bench for alu_serial_ctrl (W=8).
// Expected results come from a behavioural word-level model and are queued
// when an operation is issued, then popped when done pulses.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         z;
    logic         ov;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  alu_serial_if #(.W(W)) bus ();

  alu_serial_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level reference of the serial ALU.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] bv;
    logic [W:0]   full;
    logic         cin_msb;
    bv   = op[2] ? ~b : b;
    full = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, op[2]};
    case (op[1:0])
      2'b00:   e.res = a & bv;
      2'b01:   e.res = a | bv;
      2'b10:   e.res = full[W-1:0];
      default: e.res = {{(W-1){1'b0}}, full[W-1]};
    endcase
    e.co    = full[W];
    e.z     = (e.res == '0);
    cin_msb = a[W-1] ^ bv[W-1] ^ full[W-1];
    e.ov    = (op[1:0] == 2'b10) ? (cin_msb ^ full[W]) : 1'b0;
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("result", 32'(bus.result), 32'(e.res));
        check_output("cout",   32'(bus.cout),   32'(e.co));
        check_output("zero",   32'(bus.zero),   32'(e.z));
`ifdef ALU_SERIAL_OVF_EN
        check_output("overflow", 32'(bus.overflow), 32'(e.ov));
`endif
      end
    end
  end

  // Issue one op, optionally pulse a conflicting start mid-run, and check
  // the busy flag, done latency and one-cycle done pulse.
  task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input bit inject);
    int n;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
    n    = 1;
    seen = 0;
    @(negedge clk);
    check_output("busy_run", 32'(bus.busy), 32'd1);
    while (!seen && n < 40) begin
      if (bus.done === 1'b1) begin
        seen = 1;
      end else begin
        if (inject && n == 3) begin
          bus.start = 1'b1;
          bus.op    = 3'b001;
          bus.a     = 8'hFF;
          bus.b     = 8'hFF;
        end
        if (inject && n == 4) bus.start = 1'b0;
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    check_output("done_seen", 32'(seen), 32'd1);
    check_output("done_latency", 32'(n), 32'(W + 1));
    @(negedge clk);
    check_output("done_pulse", 32'(bus.done), 32'd0);
    check_output("busy_idle",  32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int m;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_busy",   32'(bus.busy),   32'd0);
    check_output("rst_done",   32'(bus.done),   32'd0);
    check_output("rst_result", 32'(bus.result), 32'd0);
    check_output("rst_cout",   32'(bus.cout),   32'd0);
    check_output("rst_zero",   32'(bus.zero),   32'd1);
`ifdef ALU_SERIAL_OVF_EN
    check_output("rst_ovf",    32'(bus.overflow), 32'd0);
`endif
    reset = 1'b0;

    $display("[TB] arithmetic and SLT");
    apply_stimulus(3'b010, 8'h3C, 8'h05, 0);
    apply_stimulus(3'b110, 8'h05, 8'h07, 0);
    apply_stimulus(3'b111, 8'h05, 8'h07, 0);
    apply_stimulus(3'b111, 8'h07, 8'h05, 0);
    apply_stimulus(3'b111, 8'h80, 8'h01, 0);
    apply_stimulus(3'b011, 8'h70, 8'h20, 0);

    $display("[TB] logic ops");
    apply_stimulus(3'b000, 8'hF0, 8'h3C, 0);
    apply_stimulus(3'b001, 8'hF0, 8'h3C, 0);
    apply_stimulus(3'b100, 8'hF0, 8'h3C, 0);
    apply_stimulus(3'b101, 8'hF0, 8'h3C, 0);

    $display("[TB] carry and overflow boundaries");
    apply_stimulus(3'b010, 8'hFF, 8'h01, 0);
    apply_stimulus(3'b010, 8'h7F, 8'h01, 0);
    apply_stimulus(3'b110, 8'h80, 8'h01, 0);
    apply_stimulus(3'b010, 8'h10, 8'h01, 0);

    $display("[TB] start during RUN ignored");
    apply_stimulus(3'b010, 8'h3C, 8'h05, 1);

    $display("[TB] start held high");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    sb.push_back(model(3'b010, 8'h10, 8'h01));
    sb.push_back(model(3'b010, 8'h10, 8'h01));
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("held_first_done", 32'(bus.done), 32'd1);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (bus.done !== 1'b1 && m < 40);
    bus.start = 1'b0;
    check_output("held_period", 32'(m), 32'(W + 2));
    repeat (3) @(negedge clk);
    check_output("held_stops", 32'(bus.busy), 32'd0);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("mid_rst_busy",   32'(bus.busy),   32'd0);
    check_output("mid_rst_done",   32'(bus.done),   32'd0);
    check_output("mid_rst_result", 32'(bus.result), 32'd0);
    check_output("mid_rst_zero",   32'(bus.zero),   32'd1);
    reset = 1'b0;
    apply_stimulus(3'b110, 8'h80, 8'h01, 0);

    repeat (2) @(negedge clk);
    check_output("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
